// File: rtl/issue_select.sv
// Issue-queue select: one grant per cycle by max priority, round-robin tie-break,
// post-flush blackout FSM. Define ISSUE_SELECT_STARVE_BOOST_EN to add per-slot starvation boost.
module issue_select #(
  parameter int NSLOT     = 8,
  parameter int WIDTH_PRY = 2,
  parameter int WIDTH_IDX = $clog2(NSLOT),
  parameter int FLUSH_CYC = 2,
  parameter int WIDTH_AGE = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NSLOT-1:0]           i_request,
  input  logic [NSLOT*WIDTH_PRY-1:0] i_priority,
  input  logic                       i_fu_ready,
  input  logic                       i_flush,
  output logic [NSLOT-1:0]           o_grant,
  output logic                       o_valid,
  output logic [WIDTH_IDX-1:0]       o_gidx,
  output logic                       o_block
);

  if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush_cyc
    $error("issue_select: FLUSH_CYC out of range 1..15");
  end
  if (WIDTH_AGE < 1) begin : g_bad_width_age
    $error("issue_select: WIDTH_AGE must be at least 1");
  end

  typedef enum logic {ST_RUN, ST_BLOCK} state_t;

  localparam logic [3:0] BLK_INIT = 4'(FLUSH_CYC - 1);

  state_t               state;
  logic [3:0]           blk_cnt;
  logic [WIDTH_IDX-1:0] rr_ptr;
  logic                 en;
  logic [WIDTH_PRY-1:0] max_pry;
  logic [NSLOT-1:0]     cand;
  logic [NSLOT-1:0]     grant_c;
  logic                 found;
  logic [WIDTH_IDX-1:0] sel;

  // Reset gating keeps every output at 0 while i_rst_n is held low.
  assign en      = i_rst_n & i_fu_ready & ~i_flush & (state == ST_RUN);
  assign o_block = (state == ST_BLOCK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_RUN;
      blk_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_flush) begin
            state   <= ST_BLOCK;
            blk_cnt <= BLK_INIT;
          end
        end
        ST_BLOCK: begin
          if (i_flush) begin
            blk_cnt <= BLK_INIT;
          end else if (blk_cnt == 4'd0) begin
            state <= ST_RUN;
          end else begin
            blk_cnt <= blk_cnt - 4'd1;
          end
        end
        default: begin
          state   <= ST_RUN;
          blk_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ISSUE_SELECT_STARVE_BOOST_EN
  logic [WIDTH_AGE-1:0] age_q [NSLOT];
  logic [NSLOT-1:0]     sat;

  always_comb begin
    sat = '0;
    for (int k = 0; k < NSLOT; k++) begin
      sat[k] = i_request[k] && (age_q[k] == {WIDTH_AGE{1'b1}});
    end
  end

  // Counters advance on blocked cycles too, so a flush clears them explicitly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSLOT; k++) age_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (i_flush || !i_request[k] || grant_c[k]) begin
          age_q[k] <= '0;
        end else if (age_q[k] != {WIDTH_AGE{1'b1}}) begin
          age_q[k] <= age_q[k] + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    max_pry = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (i_request[k] && (i_priority[k*WIDTH_PRY +: WIDTH_PRY] > max_pry)) begin
        max_pry = i_priority[k*WIDTH_PRY +: WIDTH_PRY];
      end
    end
    cand = '0;
    for (int k = 0; k < NSLOT; k++) begin
      cand[k] = i_request[k] && (i_priority[k*WIDTH_PRY +: WIDTH_PRY] == max_pry);
    end
`ifdef ISSUE_SELECT_STARVE_BOOST_EN
    if (|sat) cand = sat;
`endif
  end

  // Circular search starting at rr_ptr; first candidate hit wins.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    grant_c = '0;
    for (int i = 0; i < NSLOT; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NSLOT;
      if (en && !found && cand[idx]) begin
        found = 1'b1;
        sel   = WIDTH_IDX'(idx);
      end
    end
    if (found) grant_c[sel] = 1'b1;
  end

  assign o_grant = grant_c;
  assign o_valid = found;
  assign o_gidx  = sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= WIDTH_IDX'((int'(sel) + 1) % NSLOT);
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: expected {block,valid,gidx,grant} words are queued
// when each step is driven and compared mid-cycle against the outputs.
module tb_issue_select;

  localparam int NSLOT = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [15:0] pri;
  logic        rdy;
  logic        fl;
  logic [7:0]  grant;
  logic        valid;
  logic [2:0]  gidx;
  logic        block;

  logic [12:0] exp_q[$];
  int          total;
  int          bad;

  issue_select #(
    .NSLOT(NSLOT), .WIDTH_PRY(2), .FLUSH_CYC(2), .WIDTH_AGE(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_priority(pri),
    .i_fu_ready(rdy), .i_flush(fl), .o_grant(grant), .o_valid(valid),
    .o_gidx(gidx), .o_block(block)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  task automatic expect_out(input logic eblk, input logic [2:0] egidx, input logic [7:0] egnt);
    exp_q.push_back({eblk, |egnt, egidx, egnt});
  endtask

  task automatic check(input string tag);
    logic [12:0] e;
    logic [12:0] o;
    o = {block, valid, gidx, grant};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s obs=%h exp=<empty queue>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tag, o, e);
      end
    end
  endtask

  // driver: apply inputs at negedge, check 1ns later, well before the next posedge
  task automatic step(input string tag, input logic [7:0] r, input logic [15:0] p,
                      input logic rd, input logic f,
                      input logic eblk, input logic [2:0] egidx, input logic [7:0] egnt);
    @(negedge clk);
    req = r; pri = p; rdy = rd; fl = f;
    expect_out(eblk, egidx, egnt);
    #1;
    check(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'hFF;
    pri   = 16'h0000;
    rdy   = 1'b1;
    fl    = 1'b0;
    #3;
    expect_out(1'b0, 3'd0, 8'h00);
    check("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h00;

    // round robin at equal priority
    step("rr_first",  8'b0010_0100, 16'h0000, 1, 0, 0, 3'd2, 8'b0000_0100);
    step("rr_second", 8'b0010_0100, 16'h0000, 1, 0, 0, 3'd5, 8'b0010_0000);
    // slot 6 wins on priority every cycle
    step("pri_hi_a", 8'hFF, 16'h7555, 1, 0, 0, 3'd6, 8'b0100_0000);
    step("pri_hi_b", 8'hFF, 16'h7555, 1, 0, 0, 3'd6, 8'b0100_0000);
    step("pri_hi_c", 8'hFF, 16'h7555, 1, 0, 0, 3'd6, 8'b0100_0000);
    // rr_ptr=7, slots 0 and 7: wrap-around
    step("wrap_7",  8'h81, 16'h0000, 1, 0, 0, 3'd7, 8'h80);
    step("wrap_0",  8'h81, 16'h0000, 1, 0, 0, 3'd0, 8'h01);
    step("wrap_7b", 8'h81, 16'h0000, 1, 0, 0, 3'd7, 8'h80);
    // FU not ready: no grant, pointer must hold at 0
    step("fu_busy",  8'h81, 16'h0000, 0, 0, 0, 3'd0, 8'h00);
    step("fu_again", 8'h81, 16'h0000, 1, 0, 0, 3'd0, 8'h01);
    step("no_req",   8'h00, 16'h0000, 1, 0, 0, 3'd0, 8'h00);
    // single flush: blackout of flush cycle + 2
    step("fl_cycle",  8'hFF, 16'h0000, 1, 1, 0, 3'd0, 8'h00);
    step("fl_blk1",   8'hFF, 16'h0000, 1, 0, 1, 3'd0, 8'h00);
    step("fl_blk2",   8'hFF, 16'h0000, 1, 0, 1, 3'd0, 8'h00);
    step("fl_resume", 8'hFF, 16'h0000, 1, 0, 0, 3'd1, 8'h02);
    // second flush inside BLOCK extends the blackout
    step("fl2_cycle",  8'hFF, 16'h0000, 1, 1, 0, 3'd0, 8'h00);
    step("fl2_blk1",   8'hFF, 16'h0000, 1, 0, 1, 3'd0, 8'h00);
    step("fl2_reload", 8'hFF, 16'h0000, 1, 1, 1, 3'd0, 8'h00);
    step("fl2_blk2",   8'hFF, 16'h0000, 1, 0, 1, 3'd0, 8'h00);
    step("fl2_blk3",   8'hFF, 16'h0000, 1, 0, 1, 3'd0, 8'h00);
    step("fl2_resume", 8'hFF, 16'h0000, 1, 0, 0, 3'd2, 8'h04);
    // asynchronous reset in the middle of BLOCK
    step("fl3_cycle", 8'hFF, 16'h0000, 1, 1, 0, 3'd0, 8'h00);
    @(negedge clk);
    fl = 1'b0;
    expect_out(1'b1, 3'd0, 8'h00);
    #1;
    check("fl3_blk_pre_rst");
    #1;
    rst_n = 1'b0;
    expect_out(1'b0, 3'd0, 8'h00);
    #1;
    check("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    expect_out(1'b0, 3'd0, 8'h01);
    #1;
    check("post_rst_grant");
    step("idle_clear", 8'h00, 16'h0000, 1, 0, 0, 3'd0, 8'h00);

`ifdef ISSUE_SELECT_STARVE_BOOST_EN
    // slot 1 (pri 0) starves behind slot 3 (pri 3) until its 2-bit age saturates
    step("boost_lose1", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("boost_lose2", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("boost_lose3", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("boost_win",   8'h0A, 16'h00C0, 1, 0, 0, 3'd1, 8'h02);
    step("boost_clear", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
`else
    // without boost the high-priority slot keeps winning
    step("noboost_a", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("noboost_b", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("noboost_c", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
    step("noboost_d", 8'h0A, 16'h00C0, 1, 0, 0, 3'd3, 8'h08);
`endif

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
